// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// serial_addsub_pkg : shared mode constants and FSM state type
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_digit.sv
// ============================================================================
// addsub_digit : combinational DIGIT-bit ripple add/subtract slice
// Revision 1.0
// ============================================================================
`default_nettype none

module addsub_digit
    import serial_addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic             mode,
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  logic             cb_i,
    output logic [DIGIT-1:0] s_dig,
    output logic             cb_o
);

    logic chain;

    // The carry/borrow ripples through a variable so the chain stays one
    // combinational path rather than a self-referencing vector.
    always_comb begin
        chain = cb_i;
        s_dig = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s_dig[i] = a_dig[i] ^ b_dig[i] ^ chain;
            if (mode == MODE_ADD) begin
                chain = (a_dig[i] & b_dig[i]) | (chain & (a_dig[i] ^ b_dig[i]));
            end else begin
                chain = (~a_dig[i] & (b_dig[i] | chain)) | (b_dig[i] & chain);
            end
        end
        cb_o = chain;
    end

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// serial_addsub : digit-serial add/subtract with carry/borrow and overflow
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cb_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             cb_out,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] DIG_MASK = WIDTH'({DIGIT{1'b1}});

    if ((DIGIT < 1) || (DIGIT > WIDTH)) begin : g_bad_digit
        $error("serial_addsub: DIGIT must lie in 1..WIDTH");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [31:0]      base;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [DIGIT-1:0] s_dig;
    logic             cb_next;
    logic [WIDTH-1:0] d_next;
    logic             ovf_next;

    assign base = 32'(cnt) * 32'(DIGIT);
    assign a_sh = a_q >> base;
    assign b_sh = b_q >> base;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .mode  (mode_q),
        .a_dig (a_sh[DIGIT-1:0]),
        .b_dig (b_sh[DIGIT-1:0]),
        .cb_i  (carry),
        .s_dig (s_dig),
        .cb_o  (cb_next)
    );

    assign d_next = (d & ~(DIG_MASK << base)) | (WIDTH'(s_dig) << base);

    // Only meaningful on the last digit, where s_dig's top bit is the result MSB.
    always_comb begin
        if (mode_q == MODE_ADD) begin
            ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_dig[DIGIT-1] != a_q[WIDTH-1]);
        end else begin
            ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_dig[DIGIT-1] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d         <= '0;
            cb_out    <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= MODE_SUB;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        mode_q   <= mode;
                        carry    <= cb_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    d     <= d_next;
                    carry <= cb_next;
                    if (cnt == LAST) begin
                        cb_out    <= cb_next;
                        ovf       <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// tb_serial_addsub : directed and randomized checks against a reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_addsub;
    import serial_addsub_pkg::*;

    typedef struct packed {
        logic        ovf;
        logic        cb;
        logic [31:0] d;
    } res_t;

    logic clk = 1'b0;
    logic rst_d;
    logic rst_sw;
    int   checks = 0;
    int   fails  = 0;
    bit   sw_done [3];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Plain integer arithmetic; overflow means the true signed result is out of range.
    function automatic res_t ref_op(input int w, input logic m, input logic [31:0] av,
                                    input logic [31:0] bv, input logic c);
        res_t   r;
        longint full, half, ua, ub, sa, sb, ur, sr, cl;
        full = longint'(1) << w;
        half = full >> 1;
        cl   = c ? 64'sd1 : 64'sd0;
        ua   = longint'({32'd0, av}) & (full - 1);
        ub   = longint'({32'd0, bv}) & (full - 1);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        if (m == MODE_ADD) begin
            ur   = ua + ub + cl;
            sr   = sa + sb + cl;
            r.cb = (ur >= full);
        end else begin
            ur   = ua - ub - cl;
            sr   = sa - sb - cl;
            r.cb = (ur < 0);
        end
        r.d   = 32'(ur & (full - 1));
        r.ovf = (sr >= half) || (sr < -half);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Directed DUT: WIDTH=16, DIGIT=4
    // ------------------------------------------------------------------
    localparam int DN = 4;
    logic        in_valid, in_ready, mode, cb_in, out_valid, out_ready, cb_out, ovf;
    logic [15:0] a, b, d;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk       (clk),
        .rst       (rst_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .cb_in     (cb_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .cb_out    (cb_out),
        .ovf       (ovf)
    );

    res_t        dq[$];
    int          d_cyc = 0;
    int          d_acc = 0;
    logic        d_prev = 1'b0;
    logic [63:0] d_held = '0;

    always @(posedge clk or posedge rst_d) begin
        if (rst_d) begin
            dq.delete();
        end else begin
            d_cyc++;
            if (in_valid && in_ready) begin
                dq.push_back(ref_op(16, mode, {16'd0, a}, {16'd0, b}, cb_in));
                d_acc = d_cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_d && out_valid && !d_prev) begin
            if (dq.size() == 0) begin
                timeout("dir_unexpected_result");
            end else begin
                res_t e;
                e = dq.pop_front();
                check("dir_latency", d_cyc - d_acc, DN);
                check("dir_d", d, e.d);
                check("dir_cb_out", cb_out, e.cb);
                check("dir_ovf", ovf, e.ovf);
                d_held = {ovf, cb_out, d};
            end
        end else if (!rst_d && out_valid) begin
            check("dir_hold", {ovf, cb_out, d}, d_held);
        end
        d_prev = out_valid;
    end

    task automatic accept16(input logic m, input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic c);
        int n = 0;
        @(negedge clk);
        mode = m; a = ta; b = tb_v; cb_in = c; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout("dir_accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        mode = 1'($urandom_range(0, 1)); cb_in = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out16(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) timeout("dir_result");
    endtask

    task automatic run16(input string name, input logic m, input logic [15:0] ta,
                         input logic [15:0] tb_v, input logic c, input logic [15:0] ed,
                         input logic ecb, input logic eovf);
        int lat;
        accept16(m, ta, tb_v, c);
        wait_out16(lat);
        check({name, "_lat"}, lat, DN);
        check({name, "_d"}, d, ed);
        check({name, "_cb"}, cb_out, ecb);
        check({name, "_ovf"}, ovf, eovf);
        @(posedge clk);
        #1;
        check({name, "_idle_ready"}, in_ready, 1'b1);
        check({name, "_idle_valid"}, out_valid, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Parameter sweep: WIDTH=32 with DIGIT = 1, 16, 8
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SW = 32;
        localparam int SD = (g == 0) ? 1 : ((g == 1) ? 16 : 8);
        localparam int SN = SW / SD;

        logic          iv, irdy, md, ci, ovl, ordy, cbo, ofl;
        logic [SW-1:0] sa, sb, sdv;

        serial_addsub #(.WIDTH(SW), .DIGIT(SD)) u_dut (
            .clk       (clk),
            .rst       (rst_sw),
            .in_valid  (iv),
            .in_ready  (irdy),
            .mode      (md),
            .a         (sa),
            .b         (sb),
            .cb_in     (ci),
            .out_valid (ovl),
            .out_ready (ordy),
            .d         (sdv),
            .cb_out    (cbo),
            .ovf       (ofl)
        );

        res_t q[$];
        int   cyc = 0;
        int   acc = 0;
        logic prev = 1'b0;

        always @(posedge clk or posedge rst_sw) begin
            if (rst_sw) begin
                q.delete();
            end else begin
                cyc++;
                if (iv && irdy) begin
                    q.push_back(ref_op(SW, md, sa, sb, ci));
                    acc = cyc;
                end
            end
        end

        always @(negedge clk) begin
            if (!rst_sw && ovl && !prev) begin
                if (q.size() == 0) begin
                    timeout("sweep_unexpected_result");
                end else begin
                    res_t e;
                    e = q.pop_front();
                    check("sweep_latency", cyc - acc, SN);
                    check("sweep_d", sdv, e.d);
                    check("sweep_cb_out", cbo, e.cb);
                    check("sweep_ovf", ofl, e.ovf);
                end
            end
            prev = ovl;
        end

        initial begin
            int n;
            iv = 1'b0; md = 1'b0; ci = 1'b0; sa = '0; sb = '0; ordy = 1'b1;
            @(negedge clk);
            while (rst_sw) @(negedge clk);
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                md = (i < 1000) ? MODE_SUB : MODE_ADD;
                sa = $urandom; sb = $urandom; ci = 1'($urandom_range(0, 1)); iv = 1'b1;
                n = 0;
                while (!irdy && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (!irdy) timeout("sweep_accept");
                @(posedge clk);
                #1;
                iv = 1'b0;
                sa = $urandom; sb = $urandom;
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!ovl && n < 100);
                if (!ovl) timeout("sweep_result");
            end
            sw_done[g] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int n;
        rst_d = 1'b1; rst_sw = 1'b1;
        in_valid = 1'b0; mode = MODE_SUB; a = '0; b = '0; cb_in = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_d", d, 16'h0000);
        check("reset_cb_out", cb_out, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        rst_d = 1'b0; rst_sw = 1'b0;

        run16("sub_5_3",       MODE_SUB, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        run16("sub_0_1",       MODE_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run16("sub_8000_1",    MODE_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run16("add_ffff_1",    MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("add_7fff_1",    MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run16("sub_eq_borrow", MODE_SUB, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Backpressure with stray in_valid pulses during RUN and DONE
        out_ready = 1'b0;
        accept16(MODE_ADD, 16'h1111, 16'h0101, 1'b0);
        in_valid = 1'b1; mode = MODE_ADD; a = 16'hAAAA; b = 16'h5555; cb_in = 1'b0;
        wait_out16(lat);
        check("bp_lat", lat, DN);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_in_ready_low", in_ready, 1'b0);
        end
        check("bp_d", d, 16'h1212);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("bp_accept_in_idle", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_out16(lat);
        check("bp_second_d", d, 16'hFFFF);
        @(posedge clk);
        #1;

        // Asynchronous reset after two RUN edges
        accept16(MODE_SUB, 16'h0100, 16'h0001, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_d = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_d", d, 16'h0000);
        check("rst_mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_d = 1'b0;
        run16("after_rst", MODE_SUB, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

        // Randomized operands with occasional consumer stalls
        for (int i = 0; i < 300; i++) begin
            accept16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                     1'($urandom_range(0, 1)));
            wait_out16(lat);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        end

        n = 0;
        while (!(sw_done[0] && sw_done[1] && sw_done[2]) && n < 100000) begin
            @(posedge clk);
            n++;
        end
        if (!(sw_done[0] && sw_done[1] && sw_done[2])) timeout("sweep_completion");
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, digit-serial add/subtract unit; successor to the 16-bit ripple full subtractor.
- Generalised in operand width and digits per cycle, with an add/subtract mode, signed-overflow flag and valid/ready handshakes on both sides.
- Processes DIGIT bits per clock, carrying the borrow/carry in a register between cycles. This trades latency for area on wide datapaths.
- Sits between operand-producing logic and any result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  unit can accept operands.
- mode  input  1  0 = subtract (A-B-cb_in), 1 = add (A+B+cb_in).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cb_in  input  1  borrow-in (sub) / carry-in (add).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference/sum.
- cb_out  output  1  borrow-out (sub) / carry-out (add).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high.
- Reset: state IDLE, in_ready=1, out_valid=0, d=0, cb_out=0, ovf=0, digit counter=0, internal carry=0.
- N = WIDTH/DIGIT. If WIDTH % DIGIT != 0, elaboration fails.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch a, b, mode and cb_in; clear counter; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes digit[cnt] (LSB digit first) through the slice.
  - Writes d[cnt*DIGIT +: DIGIT], updates the carry register and increments cnt.
  - On the edge processing cnt=N-1: register cb_out and ovf, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; d, cb_out and ovf held stable.
  - On out_ready at an edge: out_valid=0, go to IDLE. Outputs retain their last value.
- Latency: out_valid rises exactly N edges after the accepting edge. Minimum initiation interval is N+2 cycles; there is no overlap.
- Subtract slice, per bit:
  - s = a^b^bin.
  - bout = (~a&(b|bin)) | (b&bin).
- Add slice:
  - s = a^b^cin.
  - cout = (a&b) | (cin&(a^b)).
- ovf:
  - Sub: (a[W-1]!=b[W-1]) && (d[W-1]!=a[W-1]).
  - Add: (a[W-1]==b[W-1]) && (d[W-1]!=a[W-1]).
  - Uses the latched operands.
- Boundary conditions:
  - in_valid while RUN or DONE: ignored; input is not latched; in_ready=0.
  - out_ready asserted while not DONE: no effect.
  - Upstream must hold its operands only until the accepting edge.
  - DIGIT=WIDTH: N=1, single RUN cycle.
  - Reset asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded.
  - Operands change during RUN: no effect, because the latched copies are used.

Decomposition:
- Shared package holds:
  - mode constants MODE_SUB=1'b0 and MODE_ADD=1'b1;
  - FSM state typedef {IDLE, RUN, DONE}.
- Sub-module addsub_digit: combinational, parametrised by DIGIT.
  - Inputs: mode, a_dig, b_dig, cb_i.
  - Outputs: s_dig, cb_o.
  - Built as a ripple chain of the per-bit slice above.
- Top level holds the FSM, counter, operand and result registers, and the overflow logic.

Test Plan (WIDTH=16, DIGIT=4, N=4):
- Sub, a=0x0005, b=0x0003, cb_in=0, out_ready=1 -> out_valid exactly 4 edges after accept; d=0x0002, cb_out=0, ovf=0; then IDLE with in_ready=1.
- Sub, a=0x0000, b=0x0001, cb_in=0 -> d=0xFFFF, cb_out=1, ovf=0. Sub, a=0x8000, b=0x0001 -> d=0x7FFF, cb_out=0, ovf=1.
- Add, a=0xFFFF, b=0x0001, cb_in=0 -> d=0x0000, cb_out=1, ovf=0. Add, a=0x7FFF, b=0x0001 -> d=0x8000, ovf=1. Sub, a=0x1234, b=0x1234, cb_in=1 -> d=0xFFFF, cb_out=1.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> d, cb_out, ovf and out_valid stable. in_valid pulses with a=0xAAAA during RUN and DONE are ignored; the next accept occurs only in IDLE.
- Reset mid-op: assert rst after 2 RUN edges -> out_valid=0, d=0, in_ready=1 at once. A following a=0x0010, b=0x0001 sub returns 0x000F.
- Parameter sweep (DIGIT=1, 16 and 8; WIDTH=32): 1000 random operands per mode against a reference model. Latency equals WIDTH/DIGIT edges in every case.
